// File: rtl/spi_adc_pkg.sv
// spi_adc_pkg: frame geometry and FSM encoding shared by the ADC responder and the SPI master.
package spi_adc_pkg;
    localparam int FRAME_BITS = 16;
    localparam int DATA_BITS = 12;
    localparam int SYNC_STAGES = 2;
    localparam int CNT_W = 5;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAME_BITS + 1);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: synchronizes an asynchronous pin and emits registered one-cycle rise/fall events.
module spi_sync_edge #(
    parameter int STAGES = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic sync,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sync_q, sync_d;
    logic prev_q, rise_q, rise_d, fall_q, fall_d;
    always_comb begin
        sync_d = STAGES'({sync_q, d});
        rise_d = sync_q[STAGES-1] & ~prev_q;
        fall_d = ~sync_q[STAGES-1] & prev_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= sync_q[STAGES-1];
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end
    assign sync = sync_q[STAGES-1];
    assign rise = rise_q;
    assign fall = fall_q;
endmodule

// File: rtl/spi_adc_responder.sv
// spi_adc_responder: SPI mode-0 responder emulating a 12-bit ADC; serves {zeros, sample} and captures MOSI.
module spi_adc_responder
    import spi_adc_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_BITS-1:0]  sample_in,
    input  logic                  sample_valid,
    input  logic                  spi_sck,
    input  logic                  spi_cs_n,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic                  miso_oe,
    output logic [FRAME_BITS-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  frame_err,
    output logic                  busy
);
    logic sck_rise, sck_fall, cs_rise, cs_fall, mosi_s;
    logic unused_sck_sync, unused_cs_sync, unused_mosi_rise, unused_mosi_fall;
    logic [1:0] state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [FRAME_BITS-1:0] tx_q, tx_d, rx_q, rx_d, rx_data_q, rx_data_d;
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic miso_q, miso_d, oe_q, oe_d, ovr_q, ovr_d, pend_q, pend_d;
    logic rx_valid_q, rx_valid_d, err_q, err_d;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
        .clk(clk), .reset(reset), .d(spi_sck),
        .sync(unused_sck_sync), .rise(sck_rise), .fall(sck_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
        .clk(clk), .reset(reset), .d(spi_cs_n),
        .sync(unused_cs_sync), .rise(cs_rise), .fall(cs_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
        .clk(clk), .reset(reset), .d(spi_mosi),
        .sync(mosi_s), .rise(unused_mosi_rise), .fall(unused_mosi_fall)
    );

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        tx_d = tx_q;
        rx_d = rx_q;
        miso_d = miso_q;
        oe_d = oe_q;
        ovr_d = ovr_q;
        pend_d = pend_q;
        rx_data_d = rx_data_q;
        rx_valid_d = 1'b0;
        err_d = 1'b0;
        hold_d = sample_valid ? sample_in : hold_q;
        if (state_q == S_IDLE) begin
            if (cs_fall || pend_q) begin
                state_d = S_SHIFT;
                tx_d = {{(FRAME_BITS-DATA_BITS){1'b0}}, hold_q};
                rx_d = '0;
                cnt_d = '0;
                miso_d = tx_d[FRAME_BITS-1];
                oe_d = 1'b1;
                ovr_d = 1'b0;
                pend_d = 1'b0;
            end
        end else if (state_q == S_SHIFT) begin
            if (sck_rise) begin
                rx_d = {rx_q[FRAME_BITS-2:0], mosi_s};
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
            end
            // the last in-frame fall shifts in a zero; only falls past the frame count as overrun
            if (sck_fall) begin
                if (cnt_q < CNT_FULL) begin
                    tx_d = tx_q << 1;
                    miso_d = tx_q[FRAME_BITS-2];
                end else begin
                    miso_d = 1'b0;
                    ovr_d = ovr_q | (cnt_q > CNT_FULL);
                end
            end
            if (cs_rise) begin
                oe_d = 1'b0;
                miso_d = 1'b0;
                if (cnt_d == CNT_FULL && !ovr_d) begin
                    state_d = S_DONE;
                    rx_data_d = rx_d;
                    rx_valid_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                    err_d = 1'b1;
                end
            end
        end else begin
            state_d = S_IDLE;
            pend_d = cs_fall;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q <= '0;
            tx_q <= '0;
            rx_q <= '0;
            hold_q <= '0;
            miso_q <= 1'b0;
            oe_q <= 1'b0;
            ovr_q <= 1'b0;
            pend_q <= 1'b0;
            rx_data_q <= '0;
            rx_valid_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            tx_q <= tx_d;
            rx_q <= rx_d;
            hold_q <= hold_d;
            miso_q <= miso_d;
            oe_q <= oe_d;
            ovr_q <= ovr_d;
            pend_q <= pend_d;
            rx_data_q <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            err_q <= err_d;
        end
    end

    assign spi_miso = miso_q;
    assign miso_oe = oe_q;
    assign rx_data = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign frame_err = err_q;
    assign busy = (state_q == S_SHIFT);
endmodule

// File: tb/tb_spi_adc_responder.sv
// tb_spi_adc_responder: acts as a mode-0 SPI master and checks the responder against a frame-level model.
module tb_spi_adc_responder;
    logic clk = 1'b0;
    logic reset, sample_valid, spi_sck, spi_cs_n, spi_mosi;
    logic [11:0] sample_in;
    logic spi_miso, miso_oe, rx_valid, frame_err, busy;
    logic [15:0] rx_data;

    int checks = 0, failures = 0, n_valid = 0, n_err = 0;
    logic [11:0] m_hold = '0;
    logic [15:0] m_tx = '0, got_miso = '0, exp_rx = '0, m_rx_data = '0;

    spi_adc_responder dut (
        .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
        .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .miso_oe(miso_oe), .rx_data(rx_data),
        .rx_valid(rx_valid), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [11:0] v);
        sample_in = v;
        sample_valid = 1'b1;
        tick(1);
        sample_valid = 1'b0;
        m_hold = v;
    endtask

    // rx_data only ever changes to the last good frame, exactly when rx_valid pulses
    always @(negedge clk) begin
        if (!reset) begin
            check("rx_data_track", rx_data, rx_valid ? exp_rx : m_rx_data);
            if (!miso_oe) check("miso_idle", spi_miso, 1'b0);
            if (rx_valid) begin
                n_valid++;
                m_rx_data = exp_rx;
            end
            if (frame_err) n_err++;
        end
    end

    task automatic bit_cycle(input int i, input int half, input logic mb);
        logic e;
        spi_mosi = mb;
        tick(half);
        e = (i < 16) ? m_tx[15-i] : 1'b0;
        check($sformatf("miso_bit%0d", i), spi_miso, e);
        got_miso = {got_miso[14:0], spi_miso};
        spi_sck = 1'b1;
        tick(half);
        spi_sck = 1'b0;
    endtask

    // mid_at<0 loads mid_val on the cs_fall detect cycle; mid_at>=nbits never loads
    task automatic frame(input int nbits, input logic [15:0] w, input int half,
                         input int mid_at, input logic [11:0] mid_val);
        int v0, e0;
        v0 = n_valid;
        e0 = n_err;
        m_tx = {4'h0, m_hold};
        got_miso = '0;
        spi_cs_n = 1'b0;
        if (mid_at < 0) begin
            tick(3);
            load(mid_val);
        end
        tick(half);
        for (int i = 0; i < nbits; i++) begin
            if (i == mid_at) load(mid_val);
            bit_cycle(i, half, (i < 16) ? w[15-i] : 1'($urandom));
        end
        if (nbits == 16) exp_rx = w;
        tick(half);
        spi_cs_n = 1'b1;
        tick(12);
        check("rx_valid_count", n_valid - v0, (nbits == 16) ? 1 : 0);
        check("frame_err_count", n_err - e0, (nbits == 16) ? 0 : 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        sample_valid = 1'b0;
        sample_in = '0;
        spi_sck = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        tick(3);
        check("rst_miso", spi_miso, 0);
        check("rst_oe", miso_oe, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        tick(4);

        load(12'hA5C);
        frame(16, 16'h1234, 8, 99, 12'h000);
        check("t1_miso_word", got_miso, 16'h0A5C);
        check("t1_rx_data", rx_data, 16'h1234);

        frame(16, 16'hBEEF, 8, 5, 12'h3FF);
        check("t2_old_word", got_miso, 16'h0A5C);
        frame(16, 16'h5A5A, 6, 99, 12'h000);
        check("t2_new_word", got_miso, 16'h03FF);

        frame(9, 16'hFFFF, 6, 99, 12'h000);
        check("t3_rx_kept", rx_data, 16'h5A5A);
        frame(16, 16'h0F0F, 6, 99, 12'h000);
        check("t3_next_ok", rx_data, 16'h0F0F);

        frame(17, 16'hC3C3, 5, 99, 12'h000);
        check("t4_rx_kept", rx_data, 16'h0F0F);

        load(12'h111);
        frame(16, 16'h8001, 6, -1, 12'h222);
        check("t5_old_word", got_miso, 16'h0111);
        frame(16, 16'h7FFE, 6, 99, 12'h000);
        check("t5_new_word", got_miso, 16'h0222);

        m_tx = {4'h0, m_hold};
        spi_cs_n = 1'b0;
        tick(6);
        for (int i = 0; i < 5; i++) bit_cycle(i, 6, 1'b1);
        reset = 1'b1;
        #1;
        check("t6_miso", spi_miso, 0);
        check("t6_oe", miso_oe, 0);
        check("t6_rx_data", rx_data, 0);
        check("t6_rx_valid", rx_valid, 0);
        check("t6_frame_err", frame_err, 0);
        check("t6_busy", busy, 0);
        spi_cs_n = 1'b1;
        spi_sck = 1'b0;
        m_hold = '0;
        m_rx_data = '0;
        exp_rx = '0;
        tick(3);
        reset = 1'b0;
        tick(5);
        frame(16, 16'hA0A0, 6, 99, 12'h000);
        check("t6_zero_word", got_miso, 16'h0000);
        load(12'h9C3);
        frame(16, 16'h1357, 7, 99, 12'h000);
        check("t6_fresh_word", got_miso, 16'h09C3);

        for (int k = 0; k < 25; k++) begin
            int nb, r, mid;
            r = int'($urandom_range(0, 7));
            nb = (r == 0) ? int'($urandom_range(1, 15)) : (r == 1) ? int'($urandom_range(17, 18)) : 16;
            mid = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nb - 1)) : 99;
            if ($urandom_range(0, 2) == 0) load(12'($urandom));
            frame(nb, 16'($urandom), int'($urandom_range(4, 9)), mid, 12'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
